// File: rtl/riscv_pkg.sv
// Shared core-wide widths and types used by the front end.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; push while full is allowed only together with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited word fetches, buffers tagged
// responses for decode and drops stale responses after a redirect.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   inflight_next;
  logic [CW:0]     credits_used;

  logic            req_fire;
  logic            rsp_fire;
  logic            buf_push;
  logic            buf_pop;
  logic            buf_full;
  logic            buf_empty;
  logic [CW-1:0]   buf_count;
  fetch_pkt_t      buf_wdata;
  fetch_pkt_t      buf_head;

  logic [XLEN-1:0] tag_pc;
  logic            tag_full;
  logic            tag_empty;
  logic [CW-1:0]   tag_count;

  // Every slot is either in flight or buffered, so the buffer can never overflow.
  assign credits_used     = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req_valid_o = ~rst_i & (credits_used < (CW + 1)'(DEPTH));
  assign imem_req_addr_o  = pc;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;
  assign rsp_fire         = imem_rsp_valid_i;
  assign inflight_next    = outstanding + CW'(req_fire) - CW'(rsp_fire);

  assign buf_push  = rsp_fire & (drop_cnt == '0) & ~redirect_valid_i;
  assign buf_wdata = '{pc: tag_pc, instr: imem_rsp_data_i};
  assign buf_pop   = instr_valid_o & instr_ready_i;

  assign instr_valid_o = ~buf_empty & ~redirect_valid_i;
  assign instr_o       = buf_empty ? '0 : buf_head.instr;
  assign instr_pc_o    = buf_empty ? '0 : buf_head.pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= inflight_next;
      if (redirect_valid_i) begin
        pc       <= redirect_pc_i & ~64'h3;
        drop_cnt <= inflight_next;
      end else begin
        if (req_fire) pc <= pc + 64'd4;
        if (rsp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(buf_push && buf_full && !buf_pop));
      assert (!(rsp_fire && tag_empty));
      assert (!(req_fire && tag_full && !rsp_fire));
      assert (tag_count == outstanding);
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (req_fire),
    .pop   (rsp_fire),
    .flush (1'b0),
    .wdata (pc),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  sync_fifo #(.WIDTH($bits(fetch_pkt_t)), .DEPTH(DEPTH)) u_instr_buf (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (redirect_valid_i),
    .wdata (buf_wdata),
    .rdata (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

endmodule
